// File: rtl/de_pipe_reg_if.sv
// Decode-to-execute bus: decoded fields from decode and their registered copies toward execute.
// Also holds the opcode and instruction-type encodings shared by decode, execute and this stage.
`ifndef DE_PIPE_REG_DEFS
`define DE_PIPE_REG_DEFS
`define OP_LOAD   7'b0000011
`define OP_IMM    7'b0010011
`define OP_STORE  7'b0100011
`define OP_R      7'b0110011
`define OP_BRANCH 7'b1100011
`define OP_JAL    7'b1101111
`define OP_LUI    7'b0110111
`define TYPER 3'd0
`define TYPEI 3'd1
`define TYPES 3'd2
`define TYPEB 3'd3
`define TYPEU 3'd4
`define TYPEJ 3'd5
`endif

interface de_pipe_reg_if #(parameter int XLEN = 32);
  logic            D_valid_i;
  logic [6:0]      D_opcode_i;
  logic [2:0]      D_instr_type_i;
  logic [9:0]      D_funct_i;
  logic [4:0]      D_rd_i;
  logic [4:0]      D_rs1_i;
  logic [4:0]      D_rs2_i;
  logic [XLEN-1:0] D_imm_i;
  logic [XLEN-1:0] D_pc_i;
  logic [XLEN-1:0] D_default_pc_i;
  logic [XLEN-1:0] d_val1_i;
  logic [XLEN-1:0] d_val2_i;

  logic            E_valid_o;
  logic [6:0]      E_opcode_o;
  logic [2:0]      E_instr_type_o;
  logic [9:0]      E_funct_o;
  logic [4:0]      E_rd_o;
  logic [4:0]      E_rs1_o;
  logic [4:0]      E_rs2_o;
  logic [XLEN-1:0] E_imm_o;
  logic [XLEN-1:0] E_pc_o;
  logic [XLEN-1:0] E_default_pc_o;
  logic [XLEN-1:0] E_val1_o;
  logic [XLEN-1:0] E_val2_o;

  modport master (
    output D_valid_i, D_opcode_i, D_instr_type_i, D_funct_i, D_rd_i, D_rs1_i, D_rs2_i,
           D_imm_i, D_pc_i, D_default_pc_i, d_val1_i, d_val2_i,
    input  E_valid_o, E_opcode_o, E_instr_type_o, E_funct_o, E_rd_o, E_rs1_o, E_rs2_o,
           E_imm_o, E_pc_o, E_default_pc_o, E_val1_o, E_val2_o
  );

  modport slave (
    input  D_valid_i, D_opcode_i, D_instr_type_i, D_funct_i, D_rd_i, D_rs1_i, D_rs2_i,
           D_imm_i, D_pc_i, D_default_pc_i, d_val1_i, d_val2_i,
    output E_valid_o, E_opcode_o, E_instr_type_o, E_funct_o, E_rd_o, E_rs1_o, E_rs2_o,
           E_imm_o, E_pc_o, E_default_pc_o, E_val1_o, E_val2_o
  );
endinterface

// File: rtl/de_pipe_reg.sv
// Decode-to-execute pipeline register with load-use bubble insertion, mispredict flush,
// memory-stall freeze and a saturating count of inserted bubbles.
module de_pipe_reg #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  de_pipe_reg_if.slave     bus,
  input  logic             e_mispredict_i,
  input  logic             mem_stall_i,
  output logic             load_use_stall_o,
  output logic             D_flush_o,
  output logic [CNT_W-1:0] bubble_cnt_o
);

  typedef struct packed {
    logic            valid;
    logic [6:0]      opcode;
    logic [2:0]      instrType;
    logic [9:0]      funct;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] defaultPc;
    logic [XLEN-1:0] val1;
    logic [XLEN-1:0] val2;
  } eSlot_t;

  eSlot_t           e_q, e_d, dSlot;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             src1Valid, src2Valid, hazard, insertBubble;

  always_comb begin
    src1Valid = 1'b0;
    src2Valid = 1'b0;
    case (bus.D_instr_type_i)
      `TYPER, `TYPES, `TYPEB: begin
        src1Valid = 1'b1;
        src2Valid = 1'b1;
      end
      `TYPEI:  src1Valid = 1'b1;
      default: ;
    endcase
  end

  // A load in E can only forward after memory, so a dependent decode slot must wait one cycle.
  assign hazard = e_q.valid && (e_q.opcode == `OP_LOAD) && (e_q.rd != 5'd0) && bus.D_valid_i &&
                  ((src1Valid && (bus.D_rs1_i == e_q.rd)) || (src2Valid && (bus.D_rs2_i == e_q.rd)));

  assign insertBubble     = e_mispredict_i | hazard;
  assign load_use_stall_o = hazard & ~e_mispredict_i & ~mem_stall_i;
  assign D_flush_o        = e_mispredict_i & ~mem_stall_i;

  always_comb begin
    dSlot           = '0;
    dSlot.valid     = 1'b1;
    dSlot.opcode    = bus.D_opcode_i;
    dSlot.instrType = bus.D_instr_type_i;
    dSlot.funct     = bus.D_funct_i;
    dSlot.rd        = bus.D_rd_i;
    dSlot.rs1       = bus.D_rs1_i;
    dSlot.rs2       = bus.D_rs2_i;
    dSlot.imm       = bus.D_imm_i;
    dSlot.pc        = bus.D_pc_i;
    dSlot.defaultPc = bus.D_default_pc_i;
    dSlot.val1      = bus.d_val1_i;
    dSlot.val2      = bus.d_val2_i;
  end

  // Freeze beats flush beats load-use; an empty decode slot becomes an uncounted bubble.
  always_comb begin
    e_d   = e_q;
    cnt_d = cnt_q;
    if (!mem_stall_i) begin
      if (insertBubble) begin
        e_d = '0;
        if (!(&cnt_q)) cnt_d = cnt_q + CNT_W'(1);
      end else if (bus.D_valid_i) begin
        e_d = dSlot;
      end else begin
        e_d = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      e_q   <= '0;
      cnt_q <= '0;
    end else begin
      e_q   <= e_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.E_valid_o      = e_q.valid;
  assign bus.E_opcode_o     = e_q.opcode;
  assign bus.E_instr_type_o = e_q.instrType;
  assign bus.E_funct_o      = e_q.funct;
  assign bus.E_rd_o         = e_q.rd;
  assign bus.E_rs1_o        = e_q.rs1;
  assign bus.E_rs2_o        = e_q.rs2;
  assign bus.E_imm_o        = e_q.imm;
  assign bus.E_pc_o         = e_q.pc;
  assign bus.E_default_pc_o = e_q.defaultPc;
  assign bus.E_val1_o       = e_q.val1;
  assign bus.E_val2_o       = e_q.val2;
  assign bubble_cnt_o       = cnt_q;

endmodule

// File: tb/tb_de_pipe_reg.sv
// Bench for de_pipe_reg: directed vector table, randomized traffic against a rule-level model,
// and hand sequences for memory freeze, counter saturation and asynchronous reset.
`timescale 1ns/1ps
module tb_de_pipe_reg;
  localparam int XLEN    = 32;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rstN;
  logic             eMispredict, memStall, loadUseStall, dFlush;
  logic [CNT_W-1:0] bubbleCnt;

  int checks = 0;
  int errors = 0;

  de_pipe_reg_if #(.XLEN(XLEN)) bus ();

  de_pipe_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk_i            (clk),
    .rst_i            (rstN),
    .bus              (bus),
    .e_mispredict_i   (eMispredict),
    .mem_stall_i      (memStall),
    .load_use_stall_o (loadUseStall),
    .D_flush_o        (dFlush),
    .bubble_cnt_o     (bubbleCnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            valid;
    logic [6:0]      opcode;
    logic [2:0]      itype;
    logic [9:0]      funct;
    logic [4:0]      rd, rs1, rs2;
    logic [XLEN-1:0] imm, pc, dpc, v1, v2;
  } instr_t;

  typedef struct {
    instr_t     d;
    logic       mis, ms;
    logic       expStall, expFlush, expValid;
    logic [6:0] expOp;
    logic [4:0] expRd;
    int         expCnt;
  } vec_t;

  // Reference state: what execute should hold, and how many bubbles were inserted since reset.
  instr_t mE;
  int     mBubbles;

  function automatic instr_t bubble();
    instr_t b;
    b = '{default: '0};
    return b;
  endfunction

  function automatic instr_t mk(logic v, logic [6:0] op, logic [2:0] ty, logic [4:0] rd,
                                logic [4:0] rs1, logic [4:0] rs2, logic [31:0] imm, logic [31:0] v1);
    instr_t r;
    r.valid = v;  r.opcode = op; r.itype = ty;
    r.funct = imm[9:0] ^ 10'h155;
    r.rd = rd;    r.rs1 = rs1;   r.rs2 = rs2;
    r.imm = imm;  r.v1 = v1;     r.v2 = v1 ^ 32'hA5A5_0F0F;
    r.pc  = 32'h0000_1000 + {imm[13:0], 2'b00};
    r.dpc = r.pc + 32'd4;
    return r;
  endfunction

  function automatic instr_t rndInstr();
    instr_t r;
    logic [6:0] op;
    logic [2:0] ty;
    case ($urandom_range(0, 7))
      0, 1: begin op = `OP_LOAD;   ty = `TYPEI; end
      2:    begin op = `OP_IMM;    ty = `TYPEI; end
      3:    begin op = `OP_R;      ty = `TYPER; end
      4:    begin op = `OP_STORE;  ty = `TYPES; end
      5:    begin op = `OP_BRANCH; ty = `TYPEB; end
      6:    begin op = `OP_JAL;    ty = `TYPEJ; end
      default: begin op = `OP_LUI; ty = `TYPEU; end
    endcase
    r = mk($urandom_range(0, 99) < 85, op, ty, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), $urandom, $urandom);
    return r;
  endfunction

  function automatic bit readsRs1(logic [2:0] ty);
    return ty inside {`TYPER, `TYPEI, `TYPES, `TYPEB};
  endfunction

  function automatic bit readsRs2(logic [2:0] ty);
    return ty inside {`TYPER, `TYPES, `TYPEB};
  endfunction

  function automatic bit modelHazard(instr_t d);
    if (!(mE.valid && mE.opcode == `OP_LOAD && mE.rd != 5'd0 && d.valid)) return 1'b0;
    return (readsRs1(d.itype) && d.rs1 == mE.rd) || (readsRs2(d.itype) && d.rs2 == mE.rd);
  endfunction

  function automatic int modelCnt();
    return (mBubbles > CNT_MAX) ? CNT_MAX : mBubbles;
  endfunction

  task automatic modelReset();
    mE = bubble();
    mBubbles = 0;
  endtask

  task automatic modelEdge(instr_t d, logic mis, logic ms);
    if (ms) return;
    if (mis || modelHazard(d)) begin
      mE = bubble();
      mBubbles++;
    end else begin
      mE = d.valid ? d : bubble();
    end
  endtask

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(instr_t d, logic mis, logic ms);
    bus.D_valid_i      = d.valid;
    bus.D_opcode_i     = d.opcode;
    bus.D_instr_type_i = d.itype;
    bus.D_funct_i      = d.funct;
    bus.D_rd_i         = d.rd;
    bus.D_rs1_i        = d.rs1;
    bus.D_rs2_i        = d.rs2;
    bus.D_imm_i        = d.imm;
    bus.D_pc_i         = d.pc;
    bus.D_default_pc_i = d.dpc;
    bus.d_val1_i       = d.v1;
    bus.d_val2_i       = d.v2;
    eMispredict        = mis;
    memStall           = ms;
  endtask

  task automatic checkAll(string tag);
    checkOutput({tag, ".valid"}, 32'(bus.E_valid_o), 32'(mE.valid));
    checkOutput({tag, ".opcode"}, 32'(bus.E_opcode_o), 32'(mE.opcode));
    checkOutput({tag, ".type"}, 32'(bus.E_instr_type_o), 32'(mE.itype));
    checkOutput({tag, ".funct"}, 32'(bus.E_funct_o), 32'(mE.funct));
    checkOutput({tag, ".rd"}, 32'(bus.E_rd_o), 32'(mE.rd));
    checkOutput({tag, ".rs1"}, 32'(bus.E_rs1_o), 32'(mE.rs1));
    checkOutput({tag, ".rs2"}, 32'(bus.E_rs2_o), 32'(mE.rs2));
    checkOutput({tag, ".imm"}, bus.E_imm_o, mE.imm);
    checkOutput({tag, ".pc"}, bus.E_pc_o, mE.pc);
    checkOutput({tag, ".dpc"}, bus.E_default_pc_o, mE.dpc);
    checkOutput({tag, ".val1"}, bus.E_val1_o, mE.v1);
    checkOutput({tag, ".val2"}, bus.E_val2_o, mE.v2);
    checkOutput({tag, ".cnt"}, 32'(bubbleCnt), 32'(modelCnt()));
  endtask

  task automatic checkCleared(string tag);
    checkOutput({tag, ".valid"}, 32'(bus.E_valid_o), 32'd0);
    checkOutput({tag, ".opcode"}, 32'(bus.E_opcode_o), 32'd0);
    checkOutput({tag, ".rd"}, 32'(bus.E_rd_o), 32'd0);
    checkOutput({tag, ".pc"}, bus.E_pc_o, 32'd0);
    checkOutput({tag, ".val1"}, bus.E_val1_o, 32'd0);
    checkOutput({tag, ".imm"}, bus.E_imm_o, 32'd0);
    checkOutput({tag, ".cnt"}, 32'(bubbleCnt), 32'd0);
    checkOutput({tag, ".stall"}, 32'(loadUseStall), 32'd0);
  endtask

  task automatic cycleStep(string tag, instr_t d, logic mis, logic ms);
    logic expStall, expFlush;
    applyStimulus(d, mis, ms);
    expStall = modelHazard(d) && !mis && !ms;
    expFlush = mis && !ms;
    #1;
    checkOutput({tag, ".stall"}, 32'(loadUseStall), 32'(expStall));
    checkOutput({tag, ".flush"}, 32'(dFlush), 32'(expFlush));
    @(posedge clk);
    modelEdge(d, mis, ms);
    #1;
    checkAll(tag);
  endtask

  function automatic vec_t mkVec(instr_t d, logic mis, logic ms, logic st, logic fl, logic ev,
                                 logic [6:0] eo, logic [4:0] er, int ec);
    vec_t v;
    v.d = d; v.mis = mis; v.ms = ms;
    v.expStall = st; v.expFlush = fl; v.expValid = ev;
    v.expOp = eo; v.expRd = er; v.expCnt = ec;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t   vecs[15];
    instr_t lw7, addDep, held;
    int     heldCnt;

    lw7    = mk(1'b1, `OP_LOAD, `TYPEI, 5'd7, 5'd0, 5'd0, 32'd8, 32'h40);
    addDep = mk(1'b1, `OP_R, `TYPER, 5'd8, 5'd3, 5'd7, 32'd0, 32'h22);

    vecs[0]  = mkVec(mk(1'b1, `OP_IMM, `TYPEI, 5'd5, 5'd0, 5'd0, 32'd3, 32'h10), 0, 0, 0, 0, 1, `OP_IMM, 5'd5, 0);
    vecs[1]  = mkVec(mk(1'b1, `OP_LOAD, `TYPEI, 5'd7, 5'd2, 5'd0, 32'd4, 32'h30), 0, 0, 0, 0, 1, `OP_LOAD, 5'd7, 0);
    vecs[2]  = mkVec(addDep, 0, 0, 1, 0, 0, 7'd0, 5'd0, 1);
    vecs[3]  = mkVec(addDep, 0, 0, 0, 0, 1, `OP_R, 5'd8, 1);
    vecs[4]  = mkVec(mk(1'b1, `OP_LOAD, `TYPEI, 5'd0, 5'd1, 5'd0, 32'd12, 32'h5), 0, 0, 0, 0, 1, `OP_LOAD, 5'd0, 1);
    vecs[5]  = mkVec(mk(1'b1, `OP_R, `TYPER, 5'd9, 5'd0, 5'd0, 32'd0, 32'h6), 0, 0, 0, 0, 1, `OP_R, 5'd9, 1);
    vecs[6]  = mkVec(mk(1'b1, `OP_LOAD, `TYPEI, 5'd7, 5'd1, 5'd0, 32'd16, 32'h7), 0, 0, 0, 0, 1, `OP_LOAD, 5'd7, 1);
    vecs[7]  = mkVec(mk(1'b1, `OP_JAL, `TYPEJ, 5'd1, 5'd7, 5'd7, 32'd64, 32'h8), 0, 0, 0, 0, 1, `OP_JAL, 5'd1, 1);
    vecs[8]  = mkVec(mk(1'b1, `OP_LOAD, `TYPEI, 5'd7, 5'd1, 5'd0, 32'd20, 32'h9), 0, 0, 0, 0, 1, `OP_LOAD, 5'd7, 1);
    vecs[9]  = mkVec(mk(1'b1, `OP_IMM, `TYPEI, 5'd10, 5'd3, 5'd7, 32'd1, 32'hA), 0, 0, 0, 0, 1, `OP_IMM, 5'd10, 1);
    vecs[10] = mkVec(mk(1'b1, `OP_LOAD, `TYPEI, 5'd7, 5'd1, 5'd0, 32'd24, 32'hB), 0, 0, 0, 0, 1, `OP_LOAD, 5'd7, 1);
    vecs[11] = mkVec(mk(1'b1, `OP_R, `TYPER, 5'd11, 5'd7, 5'd2, 32'd0, 32'hC), 1, 0, 0, 1, 0, 7'd0, 5'd0, 2);
    vecs[12] = mkVec(mk(1'b1, `OP_LOAD, `TYPEI, 5'd7, 5'd1, 5'd0, 32'd28, 32'hD), 0, 0, 0, 0, 1, `OP_LOAD, 5'd7, 2);
    vecs[13] = mkVec(mk(1'b0, `OP_R, `TYPER, 5'd4, 5'd7, 5'd7, 32'd0, 32'hE), 0, 0, 0, 0, 0, 7'd0, 5'd0, 2);
    vecs[14] = mkVec(mk(1'b1, `OP_STORE, `TYPES, 5'd0, 5'd1, 5'd2, 32'd8, 32'hF), 0, 0, 0, 0, 1, `OP_STORE, 5'd0, 2);

    rstN = 1'b0;
    applyStimulus(bubble(), 1'b0, 1'b0);
    modelReset();
    #12;
    checkCleared("reset");
    @(negedge clk);
    rstN = 1'b1;

    $display("[TB] directed vector table");
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].d, vecs[i].mis, vecs[i].ms);
      #1;
      checkOutput($sformatf("vec%0d.stall", i), 32'(loadUseStall), 32'(vecs[i].expStall));
      checkOutput($sformatf("vec%0d.flush", i), 32'(dFlush), 32'(vecs[i].expFlush));
      @(posedge clk);
      modelEdge(vecs[i].d, vecs[i].mis, vecs[i].ms);
      #1;
      checkOutput($sformatf("vec%0d.valid", i), 32'(bus.E_valid_o), 32'(vecs[i].expValid));
      checkOutput($sformatf("vec%0d.opcode", i), 32'(bus.E_opcode_o), 32'(vecs[i].expOp));
      checkOutput($sformatf("vec%0d.rd", i), 32'(bus.E_rd_o), 32'(vecs[i].expRd));
      checkOutput($sformatf("vec%0d.cnt", i), 32'(bubbleCnt), 32'(vecs[i].expCnt));
      checkAll($sformatf("vec%0d.model", i));
    end
    checkOutput("addi.val1", vecs[0].d.v1, 32'h10);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 300; i++) begin
      cycleStep($sformatf("rnd%0d", i), rndInstr(),
                $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 15);
    end

    $display("[TB] memory freeze over pending mispredict");
    held = mk(1'b1, `OP_LOAD, `TYPEI, 5'd7, 5'd0, 5'd0, 32'h123, 32'h77);
    cycleStep("frz.load", held, 1'b0, 1'b0);
    heldCnt = modelCnt();
    for (int i = 0; i < 3; i++) begin
      cycleStep($sformatf("frz%0d", i), rndInstr(), 1'b1, 1'b1);
      checkOutput($sformatf("frz%0d.pcHeld", i), bus.E_pc_o, held.pc);
      checkOutput($sformatf("frz%0d.cntHeld", i), 32'(bubbleCnt), 32'(heldCnt));
    end
    cycleStep("frz.release", addDep, 1'b1, 1'b0);
    checkOutput("frz.release.valid", 32'(bus.E_valid_o), 32'd0);

    $display("[TB] counter saturation and asynchronous reset");
    @(negedge clk);
    rstN = 1'b0;
    modelReset();
    #1;
    checkCleared("rst2");
    @(negedge clk);
    rstN = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cycleStep($sformatf("sat%0d", k), rndInstr(), 1'b1, 1'b0);
      checkOutput($sformatf("sat%0d.cntExp", k), 32'(bubbleCnt), (k + 1 > 15) ? 32'd15 : 32'(k + 1));
    end
    cycleStep("sat.load", lw7, 1'b0, 1'b0);
    applyStimulus(addDep, 1'b0, 1'b0);
    #1;
    checkOutput("midrst.stallBefore", 32'(loadUseStall), 32'd1);
    #2;
    rstN = 1'b0;
    modelReset();
    #1;
    checkCleared("midrst");
    @(negedge clk);
    rstN = 1'b1;
    cycleStep("post.rst", addDep, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/de_pipe_reg.md
Name: de_pipe_reg

Overview:
- Decode-to-execute pipeline register, directly downstream of the decode stage.
- Captures the decoded instruction fields and the forwarded operands d_val1/d_val2, and presents them to execute as E_* signals.
- Owns load-use hazard detection and bubble insertion.
- Handles branch/jump mispredict flushes and global memory-stall freezes, and keeps a saturating bubble counter for performance monitoring.

Parameters:
- XLEN, 32, datapath width of PC, immediate and operand fields.
- CNT_W, 16, width of the saturating bubble counter.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  asynchronous active-low reset.
- D_valid_i  in  1  decode slot holds a real instruction.
- D_opcode_i  in  7  decoded opcode.
- D_instr_type_i  in  3  `TYPER/`TYPEI/`TYPES/`TYPEB/etc.
- D_funct_i  in  10  {funct7,funct3}.
- D_rd_i  in  5  destination register.
- D_rs1_i  in  5  source register 1.
- D_rs2_i  in  5  source register 2.
- D_imm_i  in  XLEN  sign-extended immediate.
- D_pc_i  in  XLEN  instruction PC.
- D_default_pc_i  in  XLEN  PC+4.
- d_val1_i  in  XLEN  forwarded source operand 1 from decode.
- d_val2_i  in  XLEN  forwarded source operand 2 from decode.
- e_mispredict_i  in  1  execute resolved a taken branch/jump; younger instructions are wrong-path.
- mem_stall_i  in  1  memory stage not ready; freeze the whole pipeline.
- E_valid_o  out  1  E slot valid.
- E_opcode_o  out  7  registered D_opcode_i.
- E_instr_type_o  out  3  registered D_instr_type_i.
- E_funct_o  out  10  registered D_funct_i.
- E_rd_o  out  5  registered D_rd_i.
- E_rs1_o  out  5  registered D_rs1_i.
- E_rs2_o  out  5  registered D_rs2_i.
- E_imm_o  out  XLEN  registered D_imm_i.
- E_pc_o  out  XLEN  registered D_pc_i.
- E_default_pc_o  out  XLEN  registered D_default_pc_i.
- E_val1_o  out  XLEN  registered d_val1_i.
- E_val2_o  out  XLEN  registered d_val2_i.
- load_use_stall_o  out  1  combinational; fetch and decode must hold their registers this cycle.
- D_flush_o  out  1  combinational; the decode register must load a bubble next edge.
- bubble_cnt_o  out  CNT_W  number of bubbles inserted, saturating.

Behaviour:
- Reset (rst_i=0, asynchronous): all E_* outputs are 0, including E_valid_o=0 and E_opcode_o=7'b0. bubble_cnt_o=0.
  - Opcode 0 matches no `OP_* code, so the bubble causes no writeback and no forwarding.
- Source validity:
  - src1 is valid for `TYPER, `TYPEI, `TYPES and `TYPEB.
  - src2 is valid for `TYPER, `TYPES and `TYPEB.
- Load-use hazard (combinational): asserted when all of the following hold:
  - E_valid_o=1 and E_opcode_o==`OP_LOAD and E_rd_o!=0;
  - D_valid_i=1;
  - (valid src1 and D_rs1_i==E_rd_o) or (valid src2 and D_rs2_i==E_rd_o).
- load_use_stall_o = hazard & ~e_mispredict_i & ~mem_stall_i.
- D_flush_o = e_mispredict_i & ~mem_stall_i.
- Next-state priority at each rising edge, highest first:
  1. mem_stall_i=1: hold every E register; counter unchanged. A pending mispredict is ignored; execute holds e_mispredict_i asserted until mem_stall_i drops.
  2. e_mispredict_i=1: load a bubble (all E fields 0) and increment the counter.
  3. Load-use hazard: load a bubble and increment the counter. Decode holds, so the same instruction re-presents next cycle with m_valM forwarding available.
  4. Otherwise: capture all D_* fields, with E_valid_o=D_valid_i. A D_valid_i=0 slot is captured as a bubble (all fields 0) and does not increment the counter.
- Latency: exactly 1 cycle from D inputs to E outputs when no stall, flush or hazard applies.
- Counter: increments by 1 per inserted bubble and saturates at 2^CNT_W-1; no wrap.
- Simultaneous events:
  - Mispredict together with a hazard: flush wins and load_use_stall_o=0.
  - mem_stall_i together with anything: freeze wins.
- Reset mid-stall: all registers clear immediately; load_use_stall_o follows the cleared E state, so it reads 0.

Test Plan:
1. Reset then normal flow: release rst_i, present an ADDI (D_rd_i=5, d_val1_i=0x10, D_imm_i=3, D_valid_i=1) → next edge E_opcode_o=`OP_IMM, E_rd_o=5, E_val1_o=0x10, E_imm_o=3, E_valid_o=1, bubble_cnt_o=0.
2. Load-use stall: E holds LW with rd=7, D presents ADD with rs2=7 → load_use_stall_o=1 for one cycle, then E becomes a bubble (E_valid_o=0, E_opcode_o=0), bubble_cnt_o=1. Next cycle stall=0 and the ADD is captured.
3. Load-use negatives:
   - LW with rd=0 and ADD with rs1=0 → no stall.
   - E holds LW rd=7, D presents JAL (`TYPEJ) → no stall.
   - D presents ADDI with rs2 field=7 → no stall.
4. Mispredict with hazard: e_mispredict_i=1 in the same cycle as a load-use hazard → D_flush_o=1, load_use_stall_o=0, E becomes a bubble, counter +1 only once.
5. Memory freeze: mem_stall_i=1 for 3 cycles with changing D inputs and e_mispredict_i=1 → E outputs constant, D_flush_o=0, counter constant. After release, the flush takes effect on the next edge.
6. Counter saturation: with CNT_W=4, force 20 consecutive mispredict bubbles → bubble_cnt_o stops at 15. Assert rst_i low mid-sequence → the counter and all E_* outputs are 0 immediately, without waiting for a clock edge.
